mmio_peripherals: RTL

- Memory-mapped peripheral controller downstream of the MEM stage. It decodes the data-memory address, write data and strobes in parallel with data RAM, and returns read data with the same one-cycle registered latency as RAM.
- Owns the board LEDs, synchronises and debounces the two photoresistor inputs, latches rising edges, and provides a 64-bit free-running cycle timer.
- WB selects output_data over RAM data when read_valid is high.

---
 rtl/periph_pkg.sv | 19 +
 rtl/photores_debouncer.sv | 72 +++++++
 rtl/mmio_peripherals.sv | 111 +++++++++++
 3 files changed

// File: rtl/periph_pkg.sv
// Shared definitions for the MMIO peripheral block: register offsets, access size
// encoding and the debouncer state encoding.
package periph_pkg;

  // Byte offsets inside the 32-byte window (address[1:0] always zero here)
  localparam logic [4:0] OFF_LED      = 5'h00;
  localparam logic [4:0] OFF_PHOTO    = 5'h04;
  localparam logic [4:0] OFF_EDGE     = 5'h08;
  localparam logic [4:0] OFF_TIMER_LO = 5'h0C;
  localparam logic [4:0] OFF_TIMER_HI = 5'h10;

  localparam logic [2:0] MEM_OP_WORD = 3'b010;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/photores_debouncer.sv
// One photoresistor channel: two-flop synchroniser followed by a debounce FSM that
// accepts a new level after DEBOUNCE_CYCLES stable cycles and pulses rise on 0->1.
module photores_debouncer
  import periph_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 27000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic      sync1_q, sync2_q;
  logic      level_q, level_d;
  logic [15:0] cnt_q, cnt_d;
  db_state_e state_q, state_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= 16'd0;
      state_q <= DB_STABLE;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    unique case (state_q)
      DB_STABLE: begin
        if (sync2_q != level_q) begin
          // A one-cycle debounce accepts the change without entering COUNTING
          if (CNT_LAST == 16'd0) begin
            level_d = sync2_q;
          end else begin
            state_d = DB_COUNTING;
            cnt_d   = 16'd1;
          end
        end
      end
      DB_COUNTING: begin
        if (sync2_q == level_q) begin
          state_d = DB_STABLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == CNT_LAST) begin
          level_d = sync2_q;
          state_d = DB_STABLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
  end

  assign level = level_q;
  assign rise  = level_d & ~level_q;

endmodule

// File: rtl/mmio_peripherals.sv
// MMIO window beside data RAM: LEDs, debounced photoresistors with edge latch, and
// an optional 64-bit cycle timer enabled by the PERIPH_TIMER_EN macro.
module mmio_peripherals
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
  parameter int unsigned DEBOUNCE_CYCLES = 27000,
  parameter bit          LED_ACTIVE_LOW  = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic [31:0] input_data,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  mem_op_length,
  input  logic [1:0]  photores,
  output logic [4:0]  led,
  output logic        hit,
  output logic [31:0] output_data,
  output logic        read_valid
);

  logic [4:0]  offset;
  logic        wr_en, rd_en;
  logic [1:0]  level, rise;
  logic [4:0]  led_q, led_d;
  logic [1:0]  edge_reg_q, edge_reg_d;
  logic [31:0] rd_word;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        unused_data_bits;

  assign hit    = (address[31:5] == BASE_ADDR[31:5]);
  assign offset = {address[4:2], 2'b00};
  assign wr_en  = hit & mem_write & (mem_op_length == MEM_OP_WORD);
  assign rd_en  = hit & mem_read;
  assign unused_data_bits = ^{address[1:0], input_data[31:5]};

  photores_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
    .clock(clock), .reset_n(reset_n), .raw(photores[0]), .level(level[0]), .rise(rise[0])
  );
  photores_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clock(clock), .reset_n(reset_n), .raw(photores[1]), .level(level[1]), .rise(rise[1])
  );

`ifdef PERIPH_TIMER_EN
  logic [63:0] timer_q, timer_d;
  logic [31:0] shadow_q, shadow_d;

  always_comb begin
    timer_d  = timer_q + 64'd1;
    shadow_d = shadow_q;
    if (rd_en && (offset == OFF_TIMER_LO)) shadow_d = timer_q[63:32];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q  <= 64'd0;
      shadow_q <= 32'd0;
    end else begin
      timer_q  <= timer_d;
      shadow_q <= shadow_d;
    end
  end
`endif

  always_comb begin
    rd_word = 32'd0;
    case (offset)
      OFF_LED:      rd_word = {27'd0, led_q};
      OFF_PHOTO:    rd_word = {30'd0, level};
      OFF_EDGE:     rd_word = {30'd0, edge_reg_q};
`ifdef PERIPH_TIMER_EN
      OFF_TIMER_LO: rd_word = timer_q[31:0];
      OFF_TIMER_HI: rd_word = shadow_q;
`endif
      default:      rd_word = 32'd0;
    endcase
  end

  // Reads sample pre-write state; a same-cycle set beats a W1C clear
  always_comb begin
    led_d      = led_q;
    edge_reg_d = edge_reg_q;
    if (wr_en && (offset == OFF_LED)) led_d = input_data[4:0];
    if (wr_en && (offset == OFF_EDGE)) edge_reg_d = edge_reg_q & ~input_data[1:0];
    edge_reg_d = edge_reg_d | rise;
    rdata_d    = rd_en ? rd_word : 32'd0;
    rvalid_d   = rd_en;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_q      <= 5'd0;
      edge_reg_q <= 2'd0;
      rdata_q    <= 32'd0;
      rvalid_q   <= 1'b0;
    end else begin
      led_q      <= led_d;
      edge_reg_q <= edge_reg_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign led         = LED_ACTIVE_LOW ? ~led_q : led_q;
  assign output_data = rdata_q;
  assign read_valid  = rvalid_q;

endmodule
